// File: rtl/amd_mem_pkg.sv
// Shared memory-subsystem constants for the SRAM-backed data memory.
// Contents:
//   - word/half-word widths for the pipeline bus and the SRAM data pins
//   - default base byte address of the data region
//   - state encodings for the SRAM controller FSM
package amd_mem_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned SRAM_DW       = 16;
  localparam int unsigned BASE_ADDR_DEF = 1024;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD_LO = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_HI = 3'd2;
  localparam logic [STATE_W-1:0] ST_WR_LO = 3'd3;
  localparam logic [STATE_W-1:0] ST_WR_HI = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request bus between the MEM stage and the SRAM controller.
// Signals:
//   rd_en, wr_en  load / store request, held until ready=1
//   address       byte address (word-aligned)
//   write_data    store data
//   read_data     load result
//   ready         0 = freeze pipeline
// Modports: master = MEM stage, slave = controller.
interface sram_controller_if;
  import amd_mem_pkg::*;

  logic              rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic              ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit accesses on an external SRAM.
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   mem_bus      pipeline request bus (slave side)
//   sram_addr    half-word address to the SRAM
//   sram_dq_out  write half-word
//   sram_dq_in   read half-word
//   sram_dq_oe   1 = controller drives DQ
//   sram_we_n    active-low write strobe
module sram_controller
  import amd_mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned ACCESS_CYC = 2,
  parameter int unsigned SRAM_AW    = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   mem_bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned CNT_W = ($clog2(ACCESS_CYC) < 2) ? 2 : $clog2(ACCESS_CYC);
  localparam int unsigned WA_W  = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYC - 1);

  logic [STATE_W-1:0] state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [WORD_W-1:0]  read_q;

  logic [WORD_W-1:0]  offset;
  logic [WA_W-1:0]    word_addr;
  logic               hi_d;
  logic               wr_d;
  logic               unused_offset_bits;

  // Address mapper: rebase, drop byte offset, wrap to the SRAM word space.
  assign offset             = mem_bus.address - WORD_W'(BASE_ADDR);
  assign word_addr          = offset[WA_W+1:2];
  assign unused_offset_bits = ^{offset[WORD_W-1:WA_W+2], offset[1:0]};

  // Next state and phase counter.
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    case (state)
      ST_IDLE: begin
        if (mem_bus.wr_en)      state_d = ST_WR_LO;
        else if (mem_bus.rd_en) state_d = ST_RD_LO;
      end
      ST_RD_LO: begin
        if (cnt == CNT_LAST) state_d = ST_RD_HI;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      ST_RD_HI: begin
        if (cnt == CNT_LAST) state_d = ST_DONE;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      ST_WR_LO: begin
        if (cnt == CNT_LAST) state_d = ST_WR_HI;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      ST_WR_HI: begin
        if (cnt == CNT_LAST) state_d = ST_DONE;
        else                 cnt_d   = cnt + CNT_W'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM pins are registered from the next state so they line up with the phase.
  assign hi_d = (state_d == ST_RD_HI) || (state_d == ST_WR_HI);
  assign wr_d = (state_d == ST_WR_LO) || (state_d == ST_WR_HI);

  // State, counter and SRAM pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      sram_addr   <= {word_addr, hi_d};
      sram_dq_out <= hi_d ? mem_bus.write_data[WORD_W-1:SRAM_DW]
                          : mem_bus.write_data[SRAM_DW-1:0];
      sram_dq_oe  <= wr_d;
      sram_we_n   <= ~wr_d;
    end
  end

  // Read latch: capture each half on the last cycle of its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_q <= '0;
    end else if (cnt == CNT_LAST) begin
      if (state == ST_RD_LO) read_q[SRAM_DW-1:0]        <= sram_dq_in;
      if (state == ST_RD_HI) read_q[WORD_W-1:SRAM_DW]   <= sram_dq_in;
    end
  end

  assign mem_bus.read_data = read_q;
  assign mem_bus.ready     = (state == ST_DONE) | (~mem_bus.rd_en & ~mem_bus.wr_en);

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller with a same-cycle SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  logic [15:0] mem [0:(1<<18)-1];

  int n_assert = 0;
  int n_fail   = 0;

  sram_controller_if ifc ();

  sram_controller #(
    .BASE_ADDR  (1024),
    .ACCESS_CYC (2),
    .SRAM_AW    (18)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_bus     (ifc.slave),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write on the clock while we_n is low.
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance until ready rises; cyc counts cycles after the request cycle.
  task automatic wait_ready(input int max, output int cyc, output bit we_seen);
    cyc     = 0;
    we_seen = 1'b0;
    do begin
      step();
      cyc++;
      if (!sram_we_n) we_seen = 1'b1;
    end while (!ifc.ready && cyc < max);
  endtask

  int cyc;
  bit we_seen;

  initial begin
    rst            = 1'b1;
    ifc.rd_en      = 1'b0;
    ifc.wr_en      = 1'b0;
    ifc.address    = 32'd0;
    ifc.write_data = 32'd0;
    step();
    step();

    // Reset state
    check("rst_ready",     32'(ifc.ready),   32'd1);
    check("rst_we_n",      32'(sram_we_n),   32'd1);
    check("rst_oe",        32'(sram_dq_oe),  32'd0);
    check("rst_addr",      32'(sram_addr),   32'd0);
    check("rst_dq_out",    32'(sram_dq_out), 32'd0);
    check("rst_read_data", ifc.read_data,    32'd0);
    rst = 1'b0;

    // Idle with no request
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_ready", 32'(ifc.ready),  32'd1);
      check("idle_we_n",  32'(sram_we_n),  32'd1);
      check("idle_oe",    32'(sram_dq_oe), 32'd0);
    end

    // Store 0xDEADBEEF @1028: two cycles per half, word index 1
    ifc.wr_en      = 1'b1;
    ifc.address    = 32'd1028;
    ifc.write_data = 32'hDEADBEEF;
    #1;
    check("st_req_ready", 32'(ifc.ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("st_lo_addr",  32'(sram_addr),   32'd2);
      check("st_lo_dq",    32'(sram_dq_out), 32'h0000BEEF);
      check("st_lo_we_n",  32'(sram_we_n),   32'd0);
      check("st_lo_oe",    32'(sram_dq_oe),  32'd1);
      check("st_lo_ready", 32'(ifc.ready),   32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      check("st_hi_addr",  32'(sram_addr),   32'd3);
      check("st_hi_dq",    32'(sram_dq_out), 32'h0000DEAD);
      check("st_hi_we_n",  32'(sram_we_n),   32'd0);
      check("st_hi_ready", 32'(ifc.ready),   32'd0);
    end
    step();
    check("st_done_ready", 32'(ifc.ready),  32'd1);
    check("st_done_we_n",  32'(sram_we_n),  32'd1);
    check("st_done_oe",    32'(sram_dq_oe), 32'd0);
    ifc.wr_en = 1'b0;
    step();
    check("st_mem2", 32'(mem[2]), 32'h0000BEEF);
    check("st_mem3", 32'(mem[3]), 32'h0000DEAD);

    // Load @1028
    ifc.rd_en   = 1'b1;
    ifc.address = 32'd1028;
    wait_ready(20, cyc, we_seen);
    check("ld_latency",   32'(cyc),      32'd5);
    check("ld_no_write",  32'(we_seen),  32'd0);
    check("ld_read_data", ifc.read_data, 32'hDEADBEEF);
    ifc.rd_en = 1'b0;
    step();

    // Both enables @1032: store wins, read_data untouched
    ifc.rd_en      = 1'b1;
    ifc.wr_en      = 1'b1;
    ifc.address    = 32'd1032;
    ifc.write_data = 32'h12345678;
    wait_ready(20, cyc, we_seen);
    check("both_latency",   32'(cyc),      32'd5);
    check("both_wrote",     32'(we_seen),  32'd1);
    check("both_read_data", ifc.read_data, 32'hDEADBEEF);
    ifc.rd_en = 1'b0;
    ifc.wr_en = 1'b0;
    step();
    check("both_mem4", 32'(mem[4]), 32'h00005678);
    check("both_mem5", 32'(mem[5]), 32'h00001234);

    // Reset during WR_HI of a store @1036
    ifc.wr_en      = 1'b1;
    ifc.address    = 32'd1036;
    ifc.write_data = 32'hA5A55A5A;
    step();
    step();
    step();
    check("rs_in_wr_hi_addr", 32'(sram_addr), 32'd7);
    rst = 1'b1;
    step();
    check("rs_we_n",      32'(sram_we_n),  32'd1);
    check("rs_oe",        32'(sram_dq_oe), 32'd0);
    check("rs_read_data", ifc.read_data,   32'd0);
    check("rs_ready",     32'(ifc.ready),  32'd0);
    rst = 1'b0;
    wait_ready(20, cyc, we_seen);
    check("rs_restart_latency", 32'(cyc), 32'd5);
    ifc.wr_en = 1'b0;
    step();
    check("rs_mem6", 32'(mem[6]), 32'h00005A5A);
    check("rs_mem7", 32'(mem[7]), 32'h0000A5A5);

    // Seed word 0, then back-to-back loads @1024 and @1028
    ifc.wr_en      = 1'b1;
    ifc.address    = 32'd1024;
    ifc.write_data = 32'hCAFEF00D;
    wait_ready(20, cyc, we_seen);
    check("seed_latency", 32'(cyc), 32'd5);
    ifc.wr_en = 1'b0;
    step();

    ifc.rd_en   = 1'b1;
    ifc.address = 32'd1024;
    wait_ready(20, cyc, we_seen);
    check("b2b_first_latency", 32'(cyc),      32'd5);
    check("b2b_first_data",    ifc.read_data, 32'hCAFEF00D);
    ifc.address = 32'd1028;
    step();
    check("b2b_gap_ready", 32'(ifc.ready), 32'd0);
    wait_ready(20, cyc, we_seen);
    check("b2b_second_latency", 32'(cyc),      32'd5);
    check("b2b_second_data",    ifc.read_data, 32'hDEADBEEF);
    ifc.rd_en = 1'b0;
    step();
    check("b2b_idle_ready", 32'(ifc.ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
